// File: rtl/jk_pkg.sv
// jk_pkg: JK action encoding and excitation helper shared by the JK counter blocks
package jk_pkg;
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_act_e;
  function automatic jk_act_e jk_excite(input logic cur, input logic nxt);
    return jk_act_e'({nxt & ~cur, ~nxt & cur});
  endfunction
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single-bit JK flip-flop with asynchronous active-low reset
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_j,
  input  logic i_k,
  output logic o_q,
  output logic o_q_bar
);
  jk_act_e w_act;
  logic r_q;
  assign w_act = jk_act_e'({i_j, i_k});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= 1'b0;
    else r_q <= w_act == JK_SET ? 1'b1 : w_act == JK_RESET ? 1'b0 : w_act == JK_TOGGLE ? ~r_q : r_q;
  assign o_q = r_q;
  assign o_q_bar = ~r_q;
endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MODULUS counter built from JK cells with cascadable terminal count
// Define JK_CNT_UPDOWN_EN for up/down counting; otherwise the counter counts up only.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] w_next, w_step, w_load, w_j, w_k;
  logic w_at_end;
  assign w_load = load_val > MAX ? MAX : load_val;
`ifdef JK_CNT_UPDOWN_EN
  assign w_at_end = up ? count == MAX : count == '0;
  assign w_step = up ? (count == MAX ? '0 : count + WIDTH'(1))
                     : (count == '0 ? MAX : count - WIDTH'(1));
`else
  logic w_unused_up;
  assign w_unused_up = up;
  assign w_at_end = count == MAX;
  assign w_step = count == MAX ? '0 : count + WIDTH'(1);
`endif
  assign w_next = load ? w_load : en ? w_step : count;
  assign tc = en & ~load & w_at_end;
  // holding is simply J=K=0 on every cell, since w_next equals count
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {w_j[i], w_k[i]} = jk_excite(count[i], w_next[i]);
    jk_cell u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_j    (w_j[i]),
      .i_k    (w_k[i]),
      .o_q    (count[i]),
      .o_q_bar()
    );
  end
endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: directed checks of jk_mod_counter including a two-digit cascade
module tb_jk_mod_counter;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0, c_en = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] count, count16, units, tens;
  logic tc, tc16, units_tc, tens_tc;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .tc(tc));
  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count16), .tc(tc16));
  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_units (
    .clk(clk), .rst_n(rst_n), .en(c_en), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .count(units), .tc(units_tc));
  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_tens (
    .clk(clk), .rst_n(rst_n), .en(units_tc), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .count(tens), .tc(tens_tc));

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    load = 1'b1; en = 1'b0; load_val = 4'(v);
    step();
    load = 1'b0;
  endtask

  initial begin
    int exp_c, pulses;
    int dn_exp[4];
    repeat (2) step();
    chk("reset_count", int'(count), 0);
    chk("reset_tc", int'(tc), 0);
    rst_n = 1'b1;
    do_load(7);
    chk("load7", int'(count), 7);
    en = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_tc", int'(tc), 0);
    #1 rst_n = 1'b1;
    step();
    chk("first_after_rst", int'(count), 1);

    do_load(0);
    en = 1'b1; up = 1'b1;
    exp_c = 0;
    for (int i = 0; i < 12; i++) begin
      chk("up_tc", int'(tc), int'(exp_c == 9));
      step();
      exp_c = (exp_c + 1) % 10;
      chk("up_count", int'(count), exp_c);
    end

    do_load(2);
    en = 1'b1; up = 1'b0;
`ifdef JK_CNT_UPDOWN_EN
    dn_exp = '{1, 0, 9, 8};
    exp_c = 2;
    for (int i = 0; i < 4; i++) begin
      chk("dn_tc", int'(tc), int'(exp_c == 0));
      step();
      exp_c = dn_exp[i];
      chk("dn_count", int'(count), exp_c);
    end
`else
    dn_exp = '{3, 4, 5, 6};
    for (int i = 0; i < 4; i++) begin
      chk("uponly_tc", int'(tc), 0);
      step();
      chk("uponly_count", int'(count), dn_exp[i]);
    end
`endif
    up = 1'b1;

    do_load(9);
    en = 1'b1;
    #1 chk("tc_at9", int'(tc), 1);
    load = 1'b1; load_val = 4'd5;
    #1 chk("load_tc_forced", int'(tc), 0);
    step();
    chk("load_prio", int'(count), 5);
    load_val = 4'd13;
    step();
    chk("load_clamp13", int'(count), 9);
    load_val = 4'd15;
    step();
    chk("load_clamp15", int'(count), 9);
    chk("load15_m16", int'(count16), 15);
    load = 1'b0;
    #1 chk("m16_tc", int'(tc16), 1);
    step();
    chk("m16_rollover", int'(count16), 0);
    chk("m10_wrap", int'(count), 0);

    do_load(4);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_count", int'(count), 4);
      chk("hold_tc", int'(tc), 0);
      chk("hold_jk", int'({dut.w_j, dut.w_k}), 0);
    end

    c_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      if (tens_tc) pulses++;
      step();
      if (i == 98) chk("cascade_99", int'(tens) * 10 + int'(units), 99);
    end
    chk("cascade_wrap", int'(tens) * 10 + int'(units), 0);
    chk("cascade_pulses", pulses, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
